// File: rtl/pixel_burst_ctrl.sv
// SRAM pixel burst controller: reads RGB pixels into a grayscale buffer, then writes buffered pixels back.
// Define PIXEL_BURST_GRAY_EN for the R+G+B adder-tree conversion; otherwise the green channel is stored.
module pixel_burst_ctrl #(
    parameter int ADDR_BITS = 16,
    parameter int MAX_PIX   = 20,
    parameter int CNT_BITS  = 5,
    parameter int SRAM_WAIT = 5
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      start,
    input  logic [ADDR_BITS-1:0]      rd_base,
    input  logic [ADDR_BITS-1:0]      wr_base,
    input  logic [CNT_BITS-1:0]       num_rd,
    input  logic [CNT_BITS-1:0]       num_wr,
    input  logic [MAX_PIX-1:0][7:0]   wr_pix,
    output logic [MAX_PIX-1:0][7:0]   rd_pix,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [ADDR_BITS-1:0]      address,
    output logic [23:0]               w_data,
    input  logic [23:0]               r_data,
    output logic                      read_enable,
    output logic                      write_enable
);

    localparam int WAIT_BITS = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
    localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(SRAM_WAIT - 1);
    localparam logic [CNT_BITS-1:0]  CNT_MAX   = CNT_BITS'(MAX_PIX);
    localparam logic [CNT_BITS-1:0]  CNT_ONE   = CNT_BITS'(1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    logic [CNT_BITS-1:0]   idx;
    logic [CNT_BITS-1:0]   idx_inc;
    logic [WAIT_BITS-1:0]  wcnt;
    logic                  wait_last;
    logic [ADDR_BITS-1:0]  wr_base_q;
    logic [CNT_BITS-1:0]   num_rd_q;
    logic [CNT_BITS-1:0]   num_wr_q;
    logic                  req_bad;

    logic                  vld_p0;
    logic [7:0]            gray_p0;

`ifdef PIXEL_BURST_GRAY_EN
    // gray ~= 0.33*(R+G+B), approximated by the shift series 1/4+1/16+1/64+1/256
    function automatic logic [7:0] to_gray(input logic [23:0] px);
        logic [9:0] sum;
        sum = 10'(px[23:16]) + 10'(px[15:8]) + 10'(px[7:0]);
        return 8'((sum >> 2) + (sum >> 4) + (sum >> 6) + (sum >> 8));
    endfunction

    assign gray_p0 = to_gray(r_data);
`else
    logic unused_chan;
    assign gray_p0     = r_data[15:8];
    assign unused_chan = ^{r_data[23:16], r_data[7:0]};
`endif

    assign idx_inc   = idx + CNT_ONE;
    assign wait_last = (wcnt == WAIT_LAST);
    assign req_bad   = (num_rd > CNT_MAX) || (num_wr > CNT_MAX);

    // ---- stage p0: SRAM read data sampled on the last wait cycle of an access ----
    assign vld_p0 = (state == READ) && wait_last;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            idx          <= '0;
            wcnt         <= '0;
            wr_base_q    <= '0;
            num_rd_q     <= '0;
            num_wr_q     <= '0;
            rd_pix       <= '0;
            address      <= '0;
            w_data       <= '0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        wr_base_q <= wr_base;
                        num_rd_q  <= num_rd;
                        num_wr_q  <= num_wr;
                        idx       <= '0;
                        wcnt      <= '0;
                        if (req_bad) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            err <= 1'b0;
                            if (num_rd != '0) begin
                                address     <= rd_base;
                                read_enable <= 1'b1;
                                busy        <= 1'b1;
                                state       <= READ;
                            end else if (num_wr != '0) begin
                                address      <= wr_base;
                                w_data       <= {3{wr_pix[0]}};
                                write_enable <= 1'b1;
                                busy         <= 1'b1;
                                state        <= WRITE;
                            end else begin
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end
                    end
                end

                READ: begin
                    if (vld_p0) begin
                        wcnt        <= '0;
                        rd_pix[idx] <= gray_p0;
                        if (idx_inc == num_rd_q) begin
                            idx         <= '0;
                            read_enable <= 1'b0;
                            if (num_wr_q != '0) begin
                                address      <= wr_base_q;
                                w_data       <= {3{wr_pix[0]}};
                                write_enable <= 1'b1;
                                state        <= WRITE;
                            end else begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end else begin
                            idx     <= idx_inc;
                            address <= address + ADDR_ONE;
                        end
                    end else begin
                        wcnt <= wcnt + WAIT_BITS'(1);
                    end
                end

                WRITE: begin
                    if (wait_last) begin
                        wcnt <= '0;
                        if (idx_inc == num_wr_q) begin
                            idx          <= '0;
                            write_enable <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            state        <= DONE;
                        end else begin
                            idx     <= idx_inc;
                            address <= address + ADDR_ONE;
                            w_data  <= {3{wr_pix[idx_inc]}};
                        end
                    end else begin
                        wcnt <= wcnt + WAIT_BITS'(1);
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_burst_ctrl.sv
// Bench for pixel_burst_ctrl: timeline model derived from request parameters, checked every cycle,
// plus literal expectations for the documented scenarios (honours PIXEL_BURST_GRAY_EN).
module tb_pixel_burst_ctrl;

    localparam int W  = 5;
    localparam int NP = 20;

`ifdef PIXEL_BURST_GRAY_EN
    localparam logic [7:0] EXP_WHITE = 8'd251;
    localparam logic [7:0] EXP_CONV  = 8'd31;
`else
    localparam logic [7:0] EXP_WHITE = 8'hFF;
    localparam logic [7:0] EXP_CONV  = 8'h20;
`endif

    logic              clk = 1'b0;
    logic              n_rst;
    logic              start;
    logic [15:0]       rd_base, wr_base;
    logic [4:0]        num_rd, num_wr;
    logic [NP-1:0][7:0] wr_pix;
    logic [NP-1:0][7:0] rd_pix;
    logic              busy, done, err;
    logic [15:0]       address;
    logic [23:0]       w_data, r_data;
    logic              read_enable, write_enable;
    int                mem_mode;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model state
    bit                 have_req = 0;
    int                 req_t0, req_nrd, req_nwr, req_mode;
    bit                 req_rej;
    logic [15:0]        req_rd_base, req_wr_base;
    logic [NP-1:0][7:0] req_wr_pix;
    logic [15:0]        exp_addr = '0;
    logic [23:0]        exp_wdata = '0;
    logic               exp_err = 1'b0;
    logic [NP-1:0][7:0] exp_rd_pix = '0;
    int                 done_c = -1;
    int                 we_cnt = 0;

    pixel_burst_ctrl #(.ADDR_BITS(16), .MAX_PIX(NP), .CNT_BITS(5), .SRAM_WAIT(W)) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .rd_base(rd_base), .wr_base(wr_base), .num_rd(num_rd), .num_wr(num_wr),
        .wr_pix(wr_pix), .rd_pix(rd_pix),
        .busy(busy), .done(done), .err(err),
        .address(address), .w_data(w_data), .r_data(r_data),
        .read_enable(read_enable), .write_enable(write_enable)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] mem_fn(input logic [15:0] a, input int mode);
        case (mode)
            0:       return 24'hFFFFFF;
            1:       return 24'h102030;
            default: return {a[7:0] ^ 8'h3C, a[15:8] + 8'h11, a[7:0] + a[15:8]};
        endcase
    endfunction

    assign r_data = mem_fn(address, mem_mode);

    function automatic int gray_ref(input logic [23:0] p);
        int s;
        s = int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
`ifdef PIXEL_BURST_GRAY_EN
        return s / 4 + s / 16 + s / 64 + s / 256;
`else
        return int'(p[15:8]);
`endif
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // per-cycle comparison against the request timeline
    always @(negedge clk) begin
        int c, k, j, tot;
        logic exp_busy, exp_done, exp_re, exp_we;
        exp_busy = 1'b0; exp_done = 1'b0; exp_re = 1'b0; exp_we = 1'b0;
        if (have_req) begin
            c   = cyc - req_t0;
            tot = req_nrd + req_nwr;
            if (c >= 1) exp_err = req_rej;
            if (c >= 1 && c <= req_nrd * W) begin
                k = (c - 1) / W;
                exp_addr = req_rd_base + 16'(k);
                exp_re = 1'b1; exp_busy = 1'b1;
            end else if (c > req_nrd * W && c <= tot * W) begin
                k = (c - 1) / W - req_nrd;
                exp_addr  = req_wr_base + 16'(k);
                exp_wdata = {3{req_wr_pix[k]}};
                exp_we = 1'b1; exp_busy = 1'b1;
            end else if (c == tot * W + 1) begin
                exp_done = 1'b1;
            end
            if (c >= 2 && (c - 1) % W == 0) begin
                j = (c - 1) / W;
                if (j >= 1 && j <= req_nrd)
                    exp_rd_pix[j-1] = 8'(gray_ref(mem_fn(req_rd_base + 16'(j - 1), req_mode)));
            end
            if (done === 1'b1) done_c = c;
            if (write_enable === 1'b1) we_cnt++;
        end
        check("busy", 160'(busy), 160'(exp_busy));
        check("done", 160'(done), 160'(exp_done));
        check("err", 160'(err), 160'(exp_err));
        check("read_enable", 160'(read_enable), 160'(exp_re));
        check("write_enable", 160'(write_enable), 160'(exp_we));
        check("address", 160'(address), 160'(exp_addr));
        check("w_data", 160'(w_data), 160'(exp_wdata));
        check("rd_pix", 160'(rd_pix), 160'(exp_rd_pix));
    end

    task automatic start_req(input logic [15:0] rb, input logic [15:0] wb, input int nr, input int nw,
                             input int mode, input bit track);
        @(negedge clk);
        #1;
        rd_base = rb; wr_base = wb; num_rd = 5'(nr); num_wr = 5'(nw);
        if (track) mem_mode = mode;
        start = 1'b1;
        if (track) begin
            req_t0      = cyc;
            req_rej     = (nr > NP) || (nw > NP);
            req_nrd     = req_rej ? 0 : nr;
            req_nwr     = req_rej ? 0 : nw;
            req_mode    = mode;
            req_rd_base = rb;
            req_wr_base = wb;
            req_wr_pix  = wr_pix;
            done_c      = -1;
            we_cnt      = 0;
            have_req    = 1'b1;
        end
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; rd_base = '0; wr_base = '0;
        num_rd = '0; num_wr = '0; wr_pix = '0; mem_mode = 0;
        repeat (3) @(negedge clk);
        #1;
        check("reset busy", 160'(busy), 160'(0));
        check("reset address", 160'(address), 160'(0));
        check("reset rd_pix", 160'(rd_pix), 160'(0));
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // gray read of white pixels at 0x0100
        start_req(16'h0100, 16'h0000, 3, 0, 0, 1);
        repeat (18) @(negedge clk);
        check("white done cycle", 160'(done_c), 160'(16));
        for (int i = 0; i < 3; i++) check("white rd_pix", 160'(rd_pix[i]), 160'(EXP_WHITE));

        // conversion of 0x102030
        start_req(16'h0300, 16'h0000, 1, 0, 1, 1);
        repeat (8) @(negedge clk);
        check("conv rd_pix0", 160'(rd_pix[0]), 160'(EXP_CONV));
        check("conv keeps rd_pix1", 160'(rd_pix[1]), 160'(EXP_WHITE));
        check("conv done cycle", 160'(done_c), 160'(6));

        // write-only burst
        wr_pix[0] = 8'h5A; wr_pix[1] = 8'h11;
        start_req(16'h0000, 16'h0200, 0, 2, 0, 1);
        repeat (13) @(negedge clk);
        check("write done cycle", 160'(done_c), 160'(11));
        check("write strobe cycles", 160'(we_cnt), 160'(10));

        // mixed read/write with address-dependent data
        for (int i = 0; i < NP; i++) wr_pix[i] = 8'(i * 37 + 5);
        start_req(16'h1234, 16'h4000, 4, 3, 2, 1);
        repeat (40) @(negedge clk);
        check("mixed done cycle", 160'(done_c), 160'(36));

        // address wrap on both bursts
        start_req(16'hFFFF, 16'hFFFE, 2, 3, 2, 1);
        repeat (30) @(negedge clk);
        check("wrap done cycle", 160'(done_c), 160'(26));

        // rejected requests, then an accepted empty request clears err
        start_req(16'h0100, 16'h0200, 21, 0, 0, 1);
        repeat (3) @(negedge clk);
        check("reject done cycle", 160'(done_c), 160'(1));
        check("reject err", 160'(err), 160'(1));
        check("reject no write", 160'(we_cnt), 160'(0));
        start_req(16'h0100, 16'h0200, 2, 25, 0, 1);
        repeat (3) @(negedge clk);
        check("reject wr err", 160'(err), 160'(1));
        start_req(16'h0100, 16'h0200, 0, 0, 0, 1);
        repeat (3) @(negedge clk);
        check("empty done cycle", 160'(done_c), 160'(1));
        check("empty clears err", 160'(err), 160'(0));

        // full-depth read and write
        start_req(16'h8000, 16'h9000, NP, NP, 2, 1);
        repeat (205) @(negedge clk);
        check("max done cycle", 160'(done_c), 160'(201));

        // start while busy is ignored
        start_req(16'h0500, 16'h0600, 2, 1, 2, 1);
        repeat (2) @(negedge clk);
        start_req(16'h7777, 16'h7777, 5, 5, 0, 0);
        repeat (20) @(negedge clk);
        check("busy-start done cycle", 160'(done_c), 160'(16));

        // asynchronous reset in cycle 7 of a read burst
        start_req(16'h0100, 16'h0000, 3, 0, 2, 1);
        repeat (6) @(negedge clk);
        #2;
        n_rst = 1'b0;
        have_req = 1'b0; exp_addr = '0; exp_wdata = '0; exp_err = 1'b0; exp_rd_pix = '0;
        #1;
        check("abort busy", 160'(busy), 160'(0));
        check("abort read_enable", 160'(read_enable), 160'(0));
        check("abort address", 160'(address), 160'(0));
        check("abort w_data", 160'(w_data), 160'(0));
        check("abort rd_pix", 160'(rd_pix), 160'(0));
        @(negedge clk);
        #1;
        n_rst = 1'b1;
        repeat (30) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_burst_ctrl.md
# pixel_burst_ctrl

Parametrised SRAM pixel burst controller for the edge-detector datapath. On a `start` pulse it reads a programmable number of 24-bit RGB pixels from consecutive SRAM addresses, converts each to an 8-bit grayscale value into a parallel output buffer, then writes a programmable number of buffered pixels back to consecutive SRAM addresses. It sits between the SRAM model/controller and the window/filter logic, and exposes a start/busy/done handshake with a fixed, wait-state-counted access timing.

## Interface
- `ADDR_BITS`, 16, SRAM address width
- `MAX_PIX`, 20, depth of the read and write pixel buffers
- `CNT_BITS`, 5, width of the pixel-count inputs and index counters; must satisfy 2^CNT_BITS > MAX_PIX
- `SRAM_WAIT`, 5, clock cycles per SRAM access, ≥1
- `clk`  in  1  clock; all state updates on the rising edge
- `n_rst`  in  1  asynchronous, active-low reset
- `start`  in  1  request pulse; sampled only in IDLE
- `rd_base`  in  ADDR_BITS  first read address
- `wr_base`  in  ADDR_BITS  first write address
- `num_rd`  in  CNT_BITS  pixels to read, 0..MAX_PIX
- `num_wr`  in  CNT_BITS  pixels to write, 0..MAX_PIX
- `wr_pix`  in  MAX_PIX×8  pixels to write; element i goes to `wr_base+i`
- `rd_pix`  out  MAX_PIX×8  registered grayscale buffer; element i from `rd_base+i`
- `busy`  out  1  high in READ and WRITE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  set when a request is rejected; cleared by the next accepted start
- `address`  out  ADDR_BITS  SRAM address
- `w_data`  out  24  SRAM write data
- `r_data`  in  24  SRAM read data
- `read_enable`  out  1  SRAM read strobe
- `write_enable`  out  1  SRAM write strobe

## Operation
- FSM states: IDLE, READ, WRITE, DONE. All outputs are registered.
- IDLE with `start`=1:
  - Latch `rd_base`, `wr_base`, `num_rd` and `num_wr`. Later changes to these inputs are ignored until the next start.
  - If `num_rd` > MAX_PIX or `num_wr` > MAX_PIX: set `err`=1 and go to DONE. No SRAM access occurs.
  - Otherwise clear `err` and go to READ. If the latched `num_rd`=0, go directly to WRITE. If both counts are 0, go to DONE.
- READ:
  - Drive `address` = rd_base+idx and `read_enable`=1.
  - A wait counter runs 0..SRAM_WAIT-1. At count SRAM_WAIT-1, sample `r_data` into `rd_pix[idx]` and increment idx.
  - After the last pixel: go to WRITE (or to DONE if num_wr=0) with idx reset to 0.
- WRITE:
  - Drive `address` = wr_base+idx, `w_data` = {3{wr_pix[idx]}}, `write_enable`=1, each held for SRAM_WAIT cycles.
  - After the last pixel: go to DONE.
- DONE: `done`=1 for exactly one cycle, then return to IDLE.
- `start` is ignored in READ, WRITE and DONE.
- Address arithmetic is modulo 2^ADDR_BITS; wrap past all-ones is legal.
- Grayscale:
  - s = R+G+B computed at 10 bits, where R=r_data[23:16], G=[15:8], B=[7:0].
  - gray = (s>>2)+(s>>4)+(s>>6)+(s>>8). The maximum is 251, so the result always fits in 8 bits with no saturation.
- Entries of `rd_pix` not read in a burst keep their previous values.

## Timing
- Reset values: state IDLE; `rd_pix` all 0; `address`, `w_data`, `read_enable`, `write_enable`, `busy`, `done`, `err` all 0.
- If `start` is sampled at edge 0, the first access is visible in cycle 1.
- Accesses are back-to-back with no gap cycles. `address`, strobe and `w_data` are stable for all SRAM_WAIT cycles of an access.
- `rd_pix[i]` updates at the edge that ends read access i.
- `done` is asserted in cycle 1+(num_rd+num_wr)·SRAM_WAIT.
- Rejected request: `err` and `done` are both high in cycle 1.
- In IDLE and DONE, both strobes are 0. `address` and `w_data` hold their last values.
- Asserting `n_rst` mid-burst immediately forces all reset values, including clearing `rd_pix`. The aborted burst produces no `done`.

## Configuration
- `PIXEL_BURST_GRAY_EN` defined: grayscale conversion as described above.
- `PIXEL_BURST_GRAY_EN` undefined: no adder tree; `rd_pix[idx]` = r_data[15:8] (green channel). All timing is identical.

## Test plan
- Gray read (SRAM_WAIT=5, macro on): rd_base=0x0100, num_rd=3, num_wr=0, r_data=0xFFFFFF → addresses 0x0100..0x0102, 5 cycles each; rd_pix[0..2]=251; `done` in cycle 16.
- Conversion: r_data=0x102030 → rd_pix[0]=31. With the macro off → 0x20.
- Write: num_rd=0, num_wr=2, wr_base=0x0200, wr_pix[0]=0x5A, wr_pix[1]=0x11 → 0x0200 with w_data 0x5A5A5A for 5 cycles, then 0x0201 with 0x111111; `write_enable` high for 10 cycles; `done` in cycle 11.
- Wrap and reject: rd_base=0xFFFF, num_rd=2 → addresses 0xFFFF then 0x0000. A request with num_rd=21 → `err`=1 and `done`=1 in cycle 1; no strobe asserted.
- Reset mid-read and busy start: `start` pulsed during READ → ignored, no extra burst. `n_rst` low in cycle 7 → all outputs 0 at once, no `done` follows.
